decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage directly downstream of fetch. Consumes the fetch valid/PC pair and the 32-bit
//  word returned by the synchronous instruction memory one cycle after the fetch address was driven.
//  Decodes fields and immediates, reads the register file, detects load-use hazards, and registers
//  the result into the decode->execute pipe register. Holds the instruction word across stalls.
// PARAMETERS
//  RESET_PC   32'h0000_0000  value of pc_o/next_pc_o after reset
//  HAZARD_EN  1              1 = load-use detection active; 0 = load_use_stall_o tied to 0
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   synchronous active-high reset
//  stall_i           in   1   hold the whole stage (output register frozen)
//  squash_i          in   1   turn the next captured output into a bubble
//  valid_i           in   1   fetch output holds a real instruction
//  pc_i              in   32  PC of the instruction from fetch
//  next_pc_i         in   32  PC+4 from fetch
//  mem_rdata_i       in   32  instruction word from instruction memory (valid the cycle after addr)
//  rs1_addr_o        out  5   register file read address 1 (combinational)
//  rs2_addr_o        out  5   register file read address 2 (combinational)
//  rs1_data_i        in   32  register file read data 1 (combinational, same cycle)
//  rs2_data_i        in   32  register file read data 2
//  ex_rd_addr_i      in   5   destination of the instruction in execute
//  ex_mem_read_i     in   1   instruction in execute is a valid load
//  load_use_stall_o  out  1   request to stall fetch and this stage's input side for one cycle
//  valid_o           out  1   registered: output holds a real instruction
//  pc_o, next_pc_o   out  32  registered PC / PC+4
//  instr_o           out  32  registered instruction word
//  rd_addr_o         out  5   registered destination (0 if the format has no rd)
//  rs1_data_o        out  32  registered operand 1
//  rs2_data_o        out  32  registered operand 2
//  imm_o             out  32  registered sign-extended immediate
//  op_class_o        out  4   registered class: 0 ALU-R,1 ALU-I,2 LOAD,3 STORE,4 BRANCH,5 JAL,
//                             6 JALR,7 LUI,8 AUIPC,9 SYSTEM,10 FENCE,15 ILLEGAL
//  illegal_o         out  1   registered: opcode unknown or instr[1:0]!=2'b11
// BEHAVIOUR
//  Reset: valid_o=0, pc_o=next_pc_o=RESET_PC, instr_o=32'h0000_0013 (NOP), all other outputs 0,
//   hold_valid=0. A reset mid-stall discards the held word.
//  Instruction source: instr = hold_valid ? hold_q : mem_rdata_i.
//  Hold register: while (stall_i|load_use_stall_o) && !hold_valid -> hold_q<=mem_rdata_i,
//   hold_valid<=1. Cleared the first cycle both are low, which consumes the held word.
//  rs1_addr_o=instr[19:15], rs2_addr_o=instr[24:20] always; x0 reads return the regfile's 0.
//  Immediates: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {19{i31},i31,i7,i[30:25],
//   i[11:8],0}; U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0}; R/other -> 0.
//  rs1 is used by R,I,LOAD,STORE,BRANCH,JALR. rs2 is used by R,STORE,BRANCH.
//  load_use_stall_o = HAZARD_EN & valid_i & ex_mem_read_i & ex_rd_addr_i!=0 & used-match.
//   Combinational; it must not depend on squash_i.
//  Output register (priority): stall_i -> hold all; else squash_i|load_use_stall_o|!valid_i ->
//   valid_o<=0 with the other fields don't-care (implementation loads the decode anyway); else
//   capture the decode with valid_o<=1. Latency is 1 cycle from mem_rdata_i to the outputs.
//  stall_i and squash_i together: stall wins and the outputs hold. Squash is applied on the
//   first unstalled cycle only if it is still asserted.
//  Illegal: op_class_o=15, illegal_o=1, rd_addr_o=0, valid_o still 1 (for the trap path).
// TESTING
//  1 reset: assert rst_i for 2 cycles -> valid_o=0, instr_o=32'h13, pc_o=RESET_PC, no X.
//  2 addi x1,x0,5 (32'h00500093), pc 0x100 -> next cycle valid_o=1, rd=1, imm=5,
//    op_class=1, next_pc_o=0x104.
//  3 lw x2,0(x1) in execute (ex_rd=2, mem_read=1), decode add x3,x2,x2 -> load_use_stall_o=1,
//    next valid_o=0. The following cycle the held add issues with the correct instruction and
//    load_use_stall_o=0.
//  4 stall_i high for 3 cycles while mem_rdata_i changes to garbage -> outputs frozen; after
//    release the original word is decoded, not the garbage.
//  5 beq with a negative offset (32'hFE000EE3) -> imm_o=32'hFFFF_FFFC. jal 32'h0080006F ->
//    imm_o=8, rd=0.
//  6 squash_i with valid_i=1 -> valid_o=0. Word 32'hFFFF_FFFF or instr[1:0]=2'b00 ->
//    illegal_o=1, op_class=15.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode bundle: the fetch valid/PC pair plus the instruction word that the
// synchronous instruction memory returns one cycle after the fetch address.
interface decode_stage_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] next_pc_i;
    logic [31:0] mem_rdata_i;

    // valid_i qualifies pc_i/next_pc_i/mem_rdata_i in the same cycle. There is no ready
    // signal. Back-pressure goes to fetch through stall_i and load_use_stall_o, and fetch
    // must hold valid_i, pc_i and next_pc_i steady for as long as either one is high.
    modport master (output valid_i, pc_i, next_pc_i, mem_rdata_i);
    modport slave  (input  valid_i, pc_i, next_pc_i, mem_rdata_i);
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage. It decodes the fetched word, reads the register file, detects
// load-use hazards and registers the result into the decode->execute pipe register.
module decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 squash_i,
    decode_stage_if.slave        fetch,
    output logic [4:0]           rs1_addr_o,
    output logic [4:0]           rs2_addr_o,
    input  logic [31:0]          rs1_data_i,
    input  logic [31:0]          rs2_data_i,
    input  logic [4:0]           ex_rd_addr_i,
    input  logic                 ex_mem_read_i,
    output logic                 load_use_stall_o,
    output logic                 valid_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          next_pc_o,
    output logic [31:0]          instr_o,
    output logic [4:0]           rd_addr_o,
    output logic [31:0]          rs1_data_o,
    output logic [31:0]          rs2_data_o,
    output logic [31:0]          imm_o,
    output logic [3:0]           op_class_o,
    output logic                 illegal_o
);

    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] hold_q;
    logic        hold_valid;
    logic [31:0] instr;
    op_class_e   cls;
    logic [31:0] imm;
    logic        has_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  rd_addr;
    logic        hold_req;

    // While the stage is held the memory has moved on, so the word seen on the first
    // held cycle is kept and replayed once the stall is released.
    assign instr      = hold_valid ? hold_q : fetch.mem_rdata_i;
    assign rs1_addr_o = instr[19:15];
    assign rs2_addr_o = instr[24:20];

    always_comb begin
        cls     = CLS_ILLEGAL;
        imm     = 32'h0;
        has_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:2])
                5'b01100: begin
                    cls = CLS_ALU_R;  has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                5'b00100: begin
                    cls = CLS_ALU_I;  has_rd = 1'b1; use_rs1 = 1'b1;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                5'b00000: begin
                    cls = CLS_LOAD;   has_rd = 1'b1; use_rs1 = 1'b1;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                5'b01000: begin
                    cls = CLS_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1;
                    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                5'b11000: begin
                    cls = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
                end
                5'b11011: begin
                    cls = CLS_JAL;    has_rd = 1'b1;
                    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
                end
                5'b11001: begin
                    cls = CLS_JALR;   has_rd = 1'b1; use_rs1 = 1'b1;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                5'b01101: begin
                    cls = CLS_LUI;    has_rd = 1'b1;
                    imm = {instr[31:12], 12'b0};
                end
                5'b00101: begin
                    cls = CLS_AUIPC;  has_rd = 1'b1;
                    imm = {instr[31:12], 12'b0};
                end
                5'b11100: begin
                    cls = CLS_SYSTEM; has_rd = 1'b1;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                5'b00011: begin
                    cls = CLS_FENCE;
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                default: cls = CLS_ILLEGAL;
            endcase
        end
    end

    assign rd_addr = has_rd ? instr[11:7] : 5'd0;

    // A use of x0 never conflicts with a load; squash must not feed back into this path.
    assign load_use_stall_o = HAZARD_EN & fetch.valid_i & ex_mem_read_i & (ex_rd_addr_i != 5'd0)
                            & ((use_rs1 & (rs1_addr_o == ex_rd_addr_i))
                             | (use_rs2 & (rs2_addr_o == ex_rd_addr_i)));

    assign hold_req = stall_i | load_use_stall_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= NOP;
            hold_valid <= 1'b0;
        end else if (hold_req && !hold_valid) begin
            hold_q     <= fetch.mem_rdata_i;
            hold_valid <= 1'b1;
        end else if (!hold_req) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            pc_o       <= RESET_PC;
            next_pc_o  <= RESET_PC;
            instr_o    <= NOP;
            rd_addr_o  <= 5'd0;
            rs1_data_o <= 32'h0;
            rs2_data_o <= 32'h0;
            imm_o      <= 32'h0;
            op_class_o <= 4'd0;
            illegal_o  <= 1'b0;
        end else if (!stall_i) begin
            valid_o    <= fetch.valid_i & !squash_i & !load_use_stall_o;
            pc_o       <= fetch.pc_i;
            next_pc_o  <= fetch.next_pc_i;
            instr_o    <= instr;
            rd_addr_o  <= rd_addr;
            rs1_data_o <= rs1_data_i;
            rs2_data_o <= rs2_data_i;
            imm_o      <= imm;
            op_class_o <= cls;
            illegal_o  <= (cls == CLS_ILLEGAL);
        end
    end

endmodule
